// File: rtl/fpu_issue_queue.sv
// Purpose: queues FPU commands, issues them one at a time to top_FPU and returns each tagged result.
// Latency: accept -> issue 1 edge; issue -> res_valid FPU_LATENCY+1 edges (3 edges accept-to-result at latency 1).
// Backpressure: in_ready drops while the FIFO is full; a held result blocks the next issue until res_ready.
module fpu_issue_queue #(
  parameter int DEPTH       = 4,
  parameter int FPU_LATENCY = 1,
  parameter int TAG_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [1:0]             operation,
  output logic [31:0]            a_fpn,
  output logic [31:0]            b_fpn,
  input  logic [31:0]            out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [TAG_W-1:0]       res_tag,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FPU_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(FPU_LATENCY);

  typedef struct packed {
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             empty, full, push;
  logic             issue, capture, drain;
  logic [CW-1:0]    wait_cnt;
  logic [TAG_W-1:0] cur_tag;

  // The extra pointer MSB separates a wrapped (full) queue from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // No fall-through: a pop on the same edge never frees a slot for a push.
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign busy     = !empty || (state != IDLE);

  // Pointer update; the read pointer advances only when a command is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{in_op, in_a, in_b, in_tag};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control strobes; a drained result and the next issue share one edge.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    drain     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          issue     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          drain = 1'b1;
          if (!empty) begin
            issue     = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FPU operand registers, latency counter and result holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      operation <= '0;
      a_fpn     <= '0;
      b_fpn     <= '0;
      cur_tag   <= '0;
      wait_cnt  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else begin
      if (issue) begin
        operation <= head.op;
        a_fpn     <= head.a;
        b_fpn     <= head.b;
        cur_tag   <= head.tag;
        wait_cnt  <= LAT;
      end else if (state == EXEC && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= out;
        res_tag   <= cur_tag;
      end else if (drain) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue with a latency-1 XOR stand-in for the FPU.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected results are hand-computed XORs of the applied operands.
module tb_fpu_issue_queue;

  localparam int DEPTH       = 4;
  localparam int FPU_LATENCY = 1;
  localparam int TAG_W       = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [1:0]        operation;
  logic [31:0]       a_fpn;
  logic [31:0]       b_fpn;
  logic [31:0]       out;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [TAG_W-1:0]  res_tag;
  logic [2:0]        count;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Stand-in FPU: one register stage, result = a XOR b.
  always @(posedge clk) out <= a_fpn ^ b_fpn;

  fpu_issue_queue #(
    .DEPTH(DEPTH), .FPU_LATENCY(FPU_LATENCY), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .operation(operation), .a_fpn(a_fpn), .b_fpn(b_fpn), .out(out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .count(count), .busy(busy)
  );

  task automatic drive_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_low got=%b want=0", in_ready); end
    rst = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (operation !== 2'd0) begin bad++; $display("FAIL reset_operation got=%h want=0", operation); end
    total++; if (a_fpn !== 32'h0) begin bad++; $display("FAIL reset_a_fpn got=%h want=0", a_fpn); end
    total++; if (b_fpn !== 32'h0) begin bad++; $display("FAIL reset_b_fpn got=%h want=0", b_fpn); end
  endtask

  task automatic test_single();
    @(negedge clk);
    drive_cmd(2'b10, 32'h41A00000, 32'h42C80000, 2'd1);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count_after_push got=%0d want=1", count); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++; if (operation !== 2'b10) begin bad++; $display("FAIL single_operation cyc=%0d got=%h want=2", c, operation); end
      total++; if (a_fpn !== 32'h41A00000) begin bad++; $display("FAIL single_a_fpn cyc=%0d got=%h want=41a00000", c, a_fpn); end
      total++; if (b_fpn !== 32'h42C80000) begin bad++; $display("FAIL single_b_fpn cyc=%0d got=%h want=42c80000", c, b_fpn); end
      total++; if (res_valid !== (c == 3)) begin bad++; $display("FAIL single_res_valid cyc=%0d got=%b want=%b", c, res_valid, (c == 3)); end
    end
    total++; if (res_data !== 32'h03680000) begin bad++; $display("FAIL single_res_data got=%h want=03680000", res_data); end
    total++; if (res_tag !== 2'd1) begin bad++; $display("FAIL single_res_tag got=%0d want=1", res_tag); end
    repeat (2) @(negedge clk);
    total++; if (res_valid !== 1'b1 || res_data !== 32'h03680000) begin bad++; $display("FAIL single_hold got=%b/%h want=1/03680000", res_valid, res_data); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b want=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    total++; if (a_fpn !== 32'h41A00000) begin bad++; $display("FAIL single_a_kept got=%h want=41a00000", a_fpn); end
  endtask

  task automatic test_fill();
    logic [31:0]      ex_d [5];
    logic [TAG_W-1:0] ex_t [5];
    int idx;
    ex_d = '{32'h3F7F00FF, 32'h3F7F00FE, 32'h3F7F00FD, 32'h3F7F00FC, 32'h3F7F00FB};
    ex_t = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        total++; if (count !== 3'd3) begin bad++; $display("FAIL fill_count_after_issue got=%0d want=3", count); end
      end
      drive_cmd(2'(k), 32'h3F800000 + k, 32'h00FF00FF, 2'(k));
    end
    @(negedge clk);
    drive_cmd(2'd1, 32'hDEADBEEF, 32'h0, 2'd1);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count_full got=%0d want=4", count); end
    repeat (8) @(negedge clk);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_refused got=%0d want=4", count); end
    in_valid = 1'b0;
    total++; if (res_valid !== 1'b1 || res_tag !== 2'd0) begin bad++; $display("FAIL fill_held got=%b/%0d want=1/0", res_valid, res_tag); end
    total++; if (res_data !== 32'h3F7F00FF) begin bad++; $display("FAIL fill_held_data got=%h want=3f7f00ff", res_data); end
    total++; if (a_fpn !== 32'h3F800000 || operation !== 2'd0) begin bad++; $display("FAIL fill_fpu_in got=%h/%0d want=3f800000/0", a_fpn, operation); end
    res_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (res_valid) begin
        total++;
        if (idx >= 5) begin
          bad++; $display("FAIL fill_extra_result got=%h want=none", res_data);
        end else if (res_data !== ex_d[idx] || res_tag !== ex_t[idx]) begin
          bad++; $display("FAIL fill_result%0d got=%h/%0d want=%h/%0d", idx, res_data, res_tag, ex_d[idx], ex_t[idx]);
        end
        idx++;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    total++; if (idx !== 5) begin bad++; $display("FAIL fill_result_count got=%0d want=5", idx); end
    total++; if (busy !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL fill_idle got=%b/%0d want=0/0", busy, count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] ex_d [4];
    int idx;
    int last_c;
    va   = '{32'h41A00000, 32'h41900000, 32'hC1C80000, 32'hC1C80000};
    vb   = '{32'h40000000, 32'h40400000, 32'h41880000, 32'hC1C80000};
    ex_d = '{32'h01A00000, 32'h01D00000, 32'h80400000, 32'h00000000};
    res_ready = 1'b1;
    idx = 0;
    last_c = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (res_valid) begin
        total++;
        if (idx >= 4) begin
          bad++; $display("FAIL b2b_extra_result got=%h want=none", res_data);
        end else if (res_data !== ex_d[idx] || res_tag !== 2'(idx)) begin
          bad++; $display("FAIL b2b_result%0d got=%h/%0d want=%h/%0d", idx, res_data, res_tag, ex_d[idx], idx);
        end
        if (idx > 0 && idx < 4) begin
          total++;
          if (c - last_c !== 3) begin bad++; $display("FAIL b2b_spacing%0d got=%0d want=3", idx, c - last_c); end
        end
        last_c = c;
        idx++;
      end
      if (c < 4) drive_cmd(2'(c), va[c], vb[c], 2'(c));
      else       in_valid = 1'b0;
    end
    res_ready = 1'b0;
    total++; if (idx !== 4) begin bad++; $display("FAIL b2b_result_count got=%0d want=4", idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", busy); end
  endtask

  task automatic test_mid_reset();
    int seen;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_cmd(2'd3, 32'h11110000 + k, 32'h0000FFFF, 2'(k + 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (count !== 3'd2 || res_valid !== 1'b0) begin bad++; $display("FAIL midrst_pre got=%0d/%b want=2/0", count, res_valid); end
    rst = 1'b1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    total++; if (count !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_count got=%0d/%b want=0/0", count, busy); end
    total++; if (operation !== 2'd0 || a_fpn !== 32'h0 || b_fpn !== 32'h0) begin bad++; $display("FAIL midrst_fpu_in got=%h/%h/%h want=0/0/0", operation, a_fpn, b_fpn); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (res_valid) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_result got=%0d want=0", seen); end
    drive_cmd(2'd1, 32'h12345678, 32'h0F0F0F0F, 2'd2);
    @(negedge clk);
    in_valid = 1'b0;
    res_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (res_valid) begin
        seen++;
        total++;
        if (res_data !== 32'h1D3B5977 || res_tag !== 2'd2) begin bad++; $display("FAIL midrst_after got=%h/%0d want=1d3b5977/2", res_data, res_tag); end
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    total++; if (seen !== 1) begin bad++; $display("FAIL midrst_after_count got=%0d want=1", seen); end
  endtask

  task automatic test_push_pop();
    logic [31:0]      ex_d [5];
    logic [TAG_W-1:0] ex_t [5];
    int idx;
    ex_d = '{32'h4040FF00, 32'h4040FF01, 32'h4040FF02, 32'h4040FF03, 32'h4040FF04};
    ex_t = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_cmd(2'd2, 32'h40400000 | k, 32'h0000FF00, 2'(k + 1));
    end
    @(negedge clk);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL pp_count_pre got=%0d want=3", count); end
    total++; if (res_valid !== 1'b1 || res_data !== ex_d[0] || res_tag !== ex_t[0]) begin bad++; $display("FAIL pp_first got=%b/%h/%0d want=1/%h/%0d", res_valid, res_data, res_tag, ex_d[0], ex_t[0]); end
    drive_cmd(2'd2, 32'h40400004, 32'h0000FF00, 2'd1);
    res_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pp_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL pp_count_same got=%0d want=3", count); end
    idx = 1;
    for (int c = 0; c < 25; c++) begin
      if (res_valid) begin
        total++;
        if (idx >= 5) begin
          bad++; $display("FAIL pp_extra_result got=%h want=none", res_data);
        end else if (res_data !== ex_d[idx] || res_tag !== ex_t[idx]) begin
          bad++; $display("FAIL pp_result%0d got=%h/%0d want=%h/%0d", idx, res_data, res_tag, ex_d[idx], ex_t[idx]);
        end
        idx++;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    total++; if (idx !== 5) begin bad++; $display("FAIL pp_result_count got=%0d want=5", idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pp_idle got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_mid_reset();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
